// File: rtl/riscv_uop_pkg.sv
// Shared micro-op definitions for the memory pipeline.
// Holds LSU state encoding, funct3 access codes and alignment helper.
package riscv_uop_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } lsu_state_t;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // size is funct3[1:0]: 00 byte, 01 half, others word
  function automatic logic lsu_misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic r;
    unique case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lo[0];
      default: r = (lo != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Store lane replication / byte enables and load lane extract.
// Purely combinational; shared by the LSU request and return paths.
module lsu_data_align
  import riscv_uop_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_st_size,
  input  logic [1:0]      i_st_ea_lo,
  input  logic [XLEN-1:0] i_st_data,
  output logic [3:0]      o_st_be,
  output logic [XLEN-1:0] o_st_wdata,
  input  logic [2:0]      i_ld_funct3,
  input  logic [1:0]      i_ld_ea_lo,
  input  logic [XLEN-1:0] i_ld_rdata,
  output logic [XLEN-1:0] o_ld_data
);

  logic [XLEN-1:0] ld_shift;

  // Byte enables follow access size; data is replicated on every lane
  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_data;
    unique case (i_st_size)
      2'b00: begin
        o_st_be    = 4'b0001 << i_st_ea_lo;
        o_st_wdata = {(XLEN/8){i_st_data[7:0]}};
      end
      2'b01: begin
        o_st_be    = i_st_ea_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {(XLEN/16){i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_shift = i_ld_rdata >> {i_ld_ea_lo, 3'b000};

  // Select addressed lane then sign/zero extend; unknown codes act as LW
  always_comb begin
    o_ld_data = ld_shift;
    unique case (i_ld_funct3)
      LSU_B:  o_ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      LSU_H:  o_ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      LSU_BU: o_ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      LSU_HU: o_ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store unit: one outstanding uop, req/gnt/rvalid memory port,
// registered one-cycle writeback pulse back to retire.
module lsu_stage
  import riscv_uop_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter bit ZERO_RD_WB = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic            i_is_store,
  input  logic [2:0]      i_funct3,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_addr_base,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_wb_valid,
  output logic            o_wb_we,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic [XLEN-1:0] o_wb_pc,
  output logic            o_misaligned
);

  lsu_state_t state_q, state_d;

  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] ea_q, ea_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic            st_q, st_d;
  logic [3:0]      be_q, be_d;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic            wb_mis_q, wb_mis_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] wb_pc_q, wb_pc_d;

  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;
  logic            mis;
  logic            accept;
  logic            complete;

  assign ea     = i_addr_base + i_imm;
  assign mis    = lsu_misaligned(i_funct3[1:0], ea[1:0]);
  assign accept = (state_q == IDLE) && i_valid && !i_flush;

  lsu_data_align #(.XLEN(XLEN)) u_align (
    .i_st_size   (i_funct3[1:0]),
    .i_st_ea_lo  (ea[1:0]),
    .i_st_data   (i_store_data),
    .o_st_be     (st_be),
    .o_st_wdata  (st_wdata),
    .i_ld_funct3 (f3_q),
    .i_ld_ea_lo  (ea_q[1:0]),
    .i_ld_rdata  (i_dmem_rdata),
    .o_ld_data   (ld_data)
  );

  // Next state, uop latch and writeback staging
  always_comb begin
    state_d   = state_q;
    ea_d      = ea_q;
    pc_d      = pc_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    st_d      = st_q;
    be_d      = be_q;
    complete  = 1'b0;
    wb_we_d   = 1'b0;
    wb_mis_d  = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_pc_d   = wb_pc_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ea_d    = ea;
          pc_d    = i_pc;
          wdata_d = st_wdata;
          f3_d    = i_funct3;
          rd_d    = i_rd;
          st_d    = i_is_store;
          be_d    = st_be;
          if (mis) begin
            complete  = 1'b1;
            wb_mis_d  = 1'b1;
            wb_rd_d   = i_rd;
            wb_pc_d   = i_pc;
            wb_data_d = '0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_dmem_gnt) begin
          if (st_q) begin
            complete  = 1'b1;
            state_d   = IDLE;
            wb_rd_d   = rd_q;
            wb_pc_d   = pc_q;
            wb_data_d = '0;
          end else begin
            // a granted load always returns data; flush must consume it
            state_d = i_flush ? DRAIN : WAIT;
          end
        end else if (i_flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (i_dmem_rvalid) begin
          complete  = 1'b1;
          state_d   = IDLE;
          wb_we_d   = !(ZERO_RD_WB && (rd_q == 5'd0));
          wb_rd_d   = rd_q;
          wb_pc_d   = pc_q;
          wb_data_d = ld_data;
        end else if (i_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_dmem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wb_valid_d = complete && !i_flush;
    wb_we_d    = wb_we_d && wb_valid_d;
    wb_mis_d   = wb_mis_d && wb_valid_d;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ea_q       <= '0;
      pc_q       <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      st_q       <= 1'b0;
      be_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_mis_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      ea_q       <= ea_d;
      pc_q       <= pc_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      st_q       <= st_d;
      be_q       <= be_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_mis_q   <= wb_mis_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_pc_q    <= wb_pc_d;
    end
  end

  assign o_stall      = i_valid && !complete && !rst;
  assign o_dmem_req   = (state_q == REQ);
  assign o_dmem_we    = st_q;
  assign o_dmem_addr  = {ea_q[XLEN-1:2], 2'b00};
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_we      = wb_we_q;
  assign o_wb_rd      = wb_rd_q;
  assign o_wb_data    = wb_data_q;
  assign o_wb_pc      = wb_pc_q;
  assign o_misaligned = wb_mis_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with a behavioural memory-op model,
// a scripted memory responder and a per-cycle compare process.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_is_store, i_flush;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic [31:0] i_imm, i_addr_base, i_store_data, i_pc;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_wb_valid, o_wb_we, o_misaligned;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data, o_wb_pc;

  lsu_stage #(.XLEN(32), .ZERO_RD_WB(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_is_store(i_is_store), .i_funct3(i_funct3),
    .i_rd(i_rd), .i_imm(i_imm), .i_addr_base(i_addr_base),
    .i_store_data(i_store_data), .i_pc(i_pc), .i_flush(i_flush),
    .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_gnt(i_dmem_gnt),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_wb_pc(o_wb_pc), .o_misaligned(o_misaligned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        we;
    logic        mis;
    logic        chk_data;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  logic        e_we;

  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_misal(input logic [31:0] ea,
                                 input logic [2:0] f3);
    return (ea % 32'(m_size(f3))) != 32'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] ea,
                                      input logic [2:0] f3);
    int sz, off;
    sz  = m_size(f3);
    off = int'(ea % 32'd4);
    off = off - (off % sz);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] sd,
                                          input logic [2:0] f3);
    int sz;
    sz = m_size(f3);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata,
                                         input logic [31:0] ea,
                                         input logic [2:0] f3);
    logic [31:0] v;
    int sz;
    sz = m_size(f3);
    v  = rdata >> (8 * (ea % 32'd4));
    if (sz == 1) v = v & 32'hFF;
    if (sz == 2) v = v & 32'hFFFF;
    if (f3 == 3'd0 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
    if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic set_model(input logic st, input logic [2:0] f3,
                           input logic [31:0] ea, input logic [31:0] sd);
    e_addr  = ea & 32'hFFFF_FFFC;
    e_be    = m_be(ea, f3);
    e_wdata = m_wdata(sd, f3);
    e_we    = st;
  endtask

  // ---------------- memory responder ----------------
  int          cfg_gnt = 0;
  int          cfg_rv  = 0;
  logic [31:0] cfg_rdata = '0;
  int          gcnt = 0;
  int          rcnt = 0;
  bit          pend = 0;

  initial begin
    i_dmem_gnt    = 1'b0;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      i_dmem_gnt    = 1'b0;
      i_dmem_rvalid = 1'b0;
      if (rst) begin
        pend = 0;
        gcnt = 0;
      end else if (o_dmem_req) begin
        if (gcnt == cfg_gnt) begin
          i_dmem_gnt = 1'b1;
          gcnt = 0;
          if (!o_dmem_we) begin
            pend = 1;
            rcnt = 0;
          end
        end else begin
          gcnt++;
        end
      end else begin
        gcnt = 0;
        if (pend) begin
          if (rcnt == cfg_rv) begin
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = cfg_rdata;
            pend = 0;
          end else begin
            rcnt++;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int          cyc = 0;
  int          req_cnt = 0;
  int          wb_cnt = 0;
  int          wb_cyc = 0;
  logic [31:0] last_addr, last_wdata, last_wb_data;
  logic [3:0]  last_be;
  logic        last_wb_we, last_wb_mis;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_dmem_req) begin
      req_cnt++;
      last_addr  = o_dmem_addr;
      last_be    = o_dmem_be;
      last_wdata = o_dmem_wdata;
      chk("req_addr", o_dmem_addr, e_addr);
      chk("req_be", 32'(o_dmem_be), 32'(e_be));
      chk("req_we", 32'(o_dmem_we), 32'(e_we));
      if (e_we) chk("req_wdata", o_dmem_wdata, e_wdata);
    end
    if (o_wb_valid) begin
      exp_t e;
      wb_cnt++;
      wb_cyc       = cyc;
      last_wb_data = o_wb_data;
      last_wb_we   = o_wb_we;
      last_wb_mis  = o_misaligned;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got pulse pc=%h want none", o_wb_pc);
      end else begin
        e = exp_q.pop_front();
        chk("wb_we", 32'(o_wb_we), 32'(e.we));
        chk("wb_mis", 32'(o_misaligned), 32'(e.mis));
        chk("wb_rd", 32'(o_wb_rd), 32'(e.rd));
        chk("wb_pc", o_wb_pc, e.pc);
        if (e.chk_data) chk("wb_data", o_wb_data, e.data);
      end
    end
  end

  // ---------------- driver ----------------
  int start_cyc = 0;
  int req0 = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] sd,
                       input logic [31:0] pc);
    i_valid      = 1'b1;
    i_is_store   = st;
    i_funct3     = f3;
    i_rd         = rd;
    i_addr_base  = base;
    i_imm        = imm;
    i_store_data = sd;
    i_pc         = pc;
  endtask

  // called at posedge+1; returns at posedge+1 after the completion edge
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] sd,
                       input logic [31:0] pc, input int gd, input int rv,
                       input logic [31:0] rdata,
                       output int ncyc, output logic [7:0] sh);
    exp_t e;
    logic [31:0] ea;
    bit done;
    ea        = base + imm;
    cfg_gnt   = gd;
    cfg_rv    = rv;
    cfg_rdata = rdata;
    set_model(st, f3, ea, sd);
    e.mis      = m_misal(ea, f3);
    e.rd       = rd;
    e.pc       = pc;
    e.we       = !st && !e.mis && (rd != 5'd0);
    e.chk_data = !st && !e.mis;
    e.data     = m_load(rdata, ea, f3);
    exp_q.push_back(e);
    start_cyc = cyc;
    req0      = req_cnt;
    drive(st, f3, rd, base, imm, sd, pc);
    ncyc = 0;
    sh   = '0;
    done = 0;
    while (!done && ncyc < 40) begin
      @(negedge clk);
      if (ncyc < 8) sh[ncyc] = o_stall;
      if (!o_stall) done = 1;
      ncyc++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got stall after %0d cycles want release", ncyc);
    end
    step(1);
    i_valid = 1'b0;
  endtask

  // wait for the writeback negedge, leave at negedge+1
  task automatic see_wb();
    @(negedge clk);
    #1;
  endtask

  localparam logic [2:0] F_B  = 3'd0;
  localparam logic [2:0] F_H  = 3'd1;
  localparam logic [2:0] F_W  = 3'd2;
  localparam logic [2:0] F_BU = 3'd4;
  localparam logic [2:0] F_HU = 3'd5;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wb0;
    logic [7:0] sh;
    rst = 1'b1;
    i_valid = 0; i_is_store = 0; i_flush = 0; i_funct3 = 0; i_rd = 0;
    i_imm = 0; i_addr_base = 0; i_store_data = 0; i_pc = 0;
    e_addr = 0; e_be = 0; e_wdata = 0; e_we = 0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_wbv", 32'(o_wb_valid), 32'd0);
    chk("rst_mis", 32'(o_misaligned), 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    step(1);
    rst = 1'b0;
    step(1);

    // LW 0x1000+4, immediate gnt, rvalid next cycle
    issue(0, F_W, 5'd1, 32'h1000, 32'd4, 32'd0, 32'h100, 0, 0,
          32'hDEAD_BEEF, n, sh);
    see_wb();
    chk("t1_addr", last_addr, 32'h1004);
    chk("t1_be", 32'(last_be), 32'hF);
    chk("t1_data", last_wb_data, 32'hDEAD_BEEF);
    chk("t1_stall", 32'(sh[2:0]), 32'b011);
    chk("t1_lat", 32'(wb_cyc - start_cyc), 32'd3);
    step(1);

    // LB / LBU at byte 3
    issue(0, F_B, 5'd2, 32'h1000, 32'd3, 32'd0, 32'h104, 0, 0,
          32'h80AA_55CC, n, sh);
    see_wb();
    chk("lb_be", 32'(last_be), 32'b1000);
    chk("lb_data", last_wb_data, 32'hFFFF_FF80);
    step(1);
    issue(0, F_BU, 5'd3, 32'h1000, 32'd3, 32'd0, 32'h108, 0, 0,
          32'h80AA_55CC, n, sh);
    see_wb();
    chk("lbu_data", last_wb_data, 32'h0000_0080);
    step(1);

    // SH upper half with grant held off three cycles
    wb0 = wb_cnt;
    issue(1, F_H, 5'd4, 32'h2000, 32'd2, 32'h1234_ABCD, 32'h10C, 3, 0,
          32'd0, n, sh);
    see_wb();
    chk("sh_reqcyc", 32'(req_cnt - req0), 32'd4);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_be", 32'(last_be), 32'b1100);
    chk("sh_we", 32'(last_wb_we), 32'd0);
    chk("sh_wbcnt", 32'(wb_cnt - wb0), 32'd1);
    chk("sh_ncyc", 32'(n), 32'd5);
    step(1);

    // LW misaligned: no request, fault next cycle, no stall
    issue(0, F_W, 5'd5, 32'h1000, 32'd1, 32'd0, 32'h110, 0, 0,
          32'd0, n, sh);
    see_wb();
    chk("mis_noreq", 32'(req_cnt - req0), 32'd0);
    chk("mis_flag", 32'(last_wb_mis), 32'd1);
    chk("mis_stall", 32'(sh[0]), 32'd0);
    chk("mis_lat", 32'(wb_cyc - start_cyc), 32'd1);
    step(1);

    // LH / LHU upper half via negative offset, delayed handshakes
    issue(0, F_H, 5'd6, 32'h3000, 32'hFFFF_FFFE, 32'd0, 32'h114, 1, 1,
          32'h8001_1234, n, sh);
    see_wb();
    chk("lh_data", last_wb_data, 32'hFFFF_8001);
    step(1);
    issue(0, F_HU, 5'd7, 32'h3000, 32'hFFFF_FFFE, 32'd0, 32'h118, 0, 2,
          32'h8001_1234, n, sh);
    step(1);

    // SB lane 1, SW, load to x0, misaligned SH
    issue(1, F_B, 5'd8, 32'h4000, 32'd1, 32'hCAFE_005A, 32'h11C, 0, 0,
          32'd0, n, sh);
    see_wb();
    chk("sb_be", 32'(last_be), 32'b0010);
    chk("sb_wdata", last_wdata, 32'h5A5A_5A5A);
    step(1);
    issue(1, F_W, 5'd9, 32'h4000, 32'd8, 32'h0BAD_F00D, 32'h120, 1, 0,
          32'd0, n, sh);
    issue(0, F_W, 5'd0, 32'h4000, 32'd8, 32'd0, 32'h124, 0, 0,
          32'h7777_0001, n, sh);
    issue(1, F_H, 5'd10, 32'h2001, 32'd0, 32'h5555, 32'h128, 0, 0,
          32'd0, n, sh);
    step(2);

    // flush in WAIT, rvalid two cycles later, next load during DRAIN
    wb0 = wb_cnt;
    set_model(0, F_W, 32'h5000, 32'd0);
    cfg_gnt = 0; cfg_rv = 2; cfg_rdata = 32'h1111_1111;
    drive(0, F_W, 5'd11, 32'h5000, 32'd0, 32'd0, 32'h200);
    step(2);
    i_flush = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("fw_noreq", 32'(o_dmem_req), 32'd0);
    step(1);
    i_flush = 1'b0;
    issue(0, F_W, 5'd12, 32'h5000, 32'd4, 32'd0, 32'h204, 0, 2,
          32'h2222_3333, n, sh);
    see_wb();
    chk("fw_ncyc", 32'(n), 32'd7);
    chk("fw_wbcnt", 32'(wb_cnt - wb0), 32'd1);
    chk("fw_data", last_wb_data, 32'h2222_3333);
    step(1);

    // flush in REQ without grant: store dropped
    wb0 = wb_cnt;
    set_model(1, F_W, 32'h6000, 32'h9999_9999);
    cfg_gnt = 5;
    drive(1, F_W, 5'd13, 32'h6000, 32'd0, 32'h9999_9999, 32'h300);
    step(1);
    i_flush = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("fr_req_c1", 32'(o_dmem_req), 32'd1);
    step(1);
    i_flush = 1'b0;
    @(negedge clk);
    chk("fr_req_c2", 32'(o_dmem_req), 32'd0);
    step(3);
    chk("fr_nowb", 32'(wb_cnt - wb0), 32'd0);

    // async reset during REQ
    wb0 = wb_cnt;
    set_model(1, F_W, 32'h7000, 32'h4444_4444);
    cfg_gnt = 5;
    drive(1, F_W, 5'd14, 32'h7000, 32'd0, 32'h4444_4444, 32'h400);
    step(1);
    @(negedge clk);
    chk("rr_req", 32'(o_dmem_req), 32'd1);
    chk("rr_stall", 32'(o_stall), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rr_req0", 32'(o_dmem_req), 32'd0);
    chk("rr_stall0", 32'(o_stall), 32'd0);
    i_valid = 1'b0;
    step(1);
    rst = 1'b0;
    step(2);
    chk("rr_nowb", 32'(wb_cnt - wb0), 32'd0);
    issue(0, F_W, 5'd15, 32'h7000, 32'd4, 32'd0, 32'h404, 0, 0,
          32'h5A5A_A5A5, n, sh);
    see_wb();
    chk("rr_after", last_wb_data, 32'h5A5A_A5A5);
    chk("rr_ncyc", 32'(n), 32'd3);
    step(2);

    chk("exp_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
